// File: rtl/square_pkg.sv
// Shared definitions for the square-root / square pair: FSM encodings, default widths
// and the 8-bit saturation limit.
package square_pkg;

    localparam int SQ_W    = 16;
    localparam int SQ_FRAC = 8;

    localparam logic [7:0] SAT_LIMIT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sq_state_t;

endpackage

// File: rtl/square_round.sv
// Combinational round-half-up of a Q(2W-2FRAC).(2FRAC) square to its integer part,
// saturated to 8 bits.
module square_round
    import square_pkg::*;
#(
    parameter int W    = SQ_W,
    parameter int FRAC = SQ_FRAC
) (
    input  logic [2*W-1:0] value,
    output logic [7:0]     rounded
);

    localparam int IW = 2*W - 2*FRAC;

    // One spare bit so that rounding up the all-ones integer part cannot wrap.
    logic [IW:0] sum;

    always_comb begin
        sum     = {1'b0, value[2*W-1:2*FRAC]} + {{IW{1'b0}}, value[2*FRAC-1]};
        rounded = (sum > (IW+1)'(SAT_LIMIT)) ? SAT_LIMIT : sum[7:0];
    end

endmodule

// File: rtl/square_from_root.sv
// Iterative shift-add squarer: Q(W-FRAC).FRAC root in, Q(2W-2FRAC).(2FRAC) square out,
// one multiplier bit per cycle. Optional rounded 8-bit output under SQUARE_ROUND_EN.
module square_from_root
    import square_pkg::*;
#(
    parameter int W    = SQ_W,
    parameter int FRAC = SQ_FRAC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_data,
`ifdef SQUARE_ROUND_EN
    output logic [7:0]     out_int,
`endif
    output logic           busy
);

    localparam int CW = $clog2(W + 1);

    generate
        if ((FRAC < 1) || (FRAC > W)) begin : g_bad_frac
            $error("square_from_root: FRAC must lie in 1..W");
        end
    endgenerate

    sq_state_t       state, state_next;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplr;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  acc_next;
    logic [CW-1:0]   cnt;
    logic            last;

    assign acc_next = acc + (mplr[0] ? mcand : '0);
    assign last     = (cnt == CW'(W - 1));

    // NOTE: state-holding blocks use non-blocking assignments only, so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SQUARE_ROUND_EN
    logic [7:0] round_val;

    square_round #(.W(W), .FRAC(FRAC)) u_round (
        .value   (acc_next),
        .rounded (round_val)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            mplr     <= '0;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
`ifdef SQUARE_ROUND_EN
            out_int  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= {{W{1'b0}}, in_data};
                        mplr  <= in_data;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    // The last partial product is folded in on the same edge that publishes.
                    if (last) begin
                        out_data <= acc_next;
`ifdef SQUARE_ROUND_EN
                        out_int  <= round_val;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_square_from_root.sv
// Directed bench for square_from_root: latency, corner operands, backpressure,
// mid-operation reset, back-to-back streaming, and out_int when SQUARE_ROUND_EN is set.
module tb_square_from_root;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
`ifdef SQUARE_ROUND_EN
    logic [7:0]  out_int;
`endif

    int vectors     = 0;
    int miscompares = 0;

    square_from_root dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SQUARE_ROUND_EN
        .out_int   (out_int),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand in IDLE, check it is taken, then count edges to out_valid.
    task automatic launch(input string tag, input logic [15:0] d, input logic [31:0] expected);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        check({tag, " ready before accept"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " in_ready low in CALC"}, 32'(in_ready), 32'd0);
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (out_valid) break;
        end
        // Accept edge plus 16 CALC edges: 17 edges in total.
        check({tag, " latency edges after accept"}, 32'(k), 32'd16);
        check({tag, " out_data"}, out_data, expected);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop back to IDLE", 32'(in_ready), 32'd1);
    endtask

    logic [15:0] ops  [3] = '{16'h0100, 16'h0200, 16'h0300};
    logic [31:0] sqs  [3] = '{32'h0001_0000, 32'h0004_0000, 32'h0009_0000};
    logic [31:0] res  [3];
    int          acc_cyc [3];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) tick();

        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
`ifdef SQUARE_ROUND_EN
        check("reset out_int", 32'(out_int), 32'd0);
`endif
        rst = 1'b0;
        tick();

        launch("4.0^2", 16'h0400, 32'h0010_0000);
        check("busy in DONE", 32'(busy), 32'd1);
`ifdef SQUARE_ROUND_EN
        check("4.0^2 out_int", 32'(out_int), 32'h10);
`endif
        pop();

        launch("0^2", 16'h0000, 32'h0000_0000);
        pop();
        launch("max^2", 16'hFFFF, 32'hFFFE_0001);
`ifdef SQUARE_ROUND_EN
        check("max^2 out_int saturated", 32'(out_int), 32'hFF);
`endif
        pop();

        // Backpressure: DONE must hold and ignore in_valid while out_ready is low.
        launch("3.0^2 held", 16'h0300, 32'h0009_0000);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 16'h0100;
            tick();
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold in_ready", 32'(in_ready), 32'd0);
            check("hold out_data", out_data, 32'h0009_0000);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        check("release to IDLE, no accept", 32'(in_ready), 32'd1);
        check("release out_valid", 32'(out_valid), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        // Reset asserted for the 8th CALC edge.
        in_valid = 1'b1;
        in_data  = 16'h0500;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset in_ready", 32'(in_ready), 32'd1);
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset out_data", out_data, 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        launch("2.0^2 after reset", 16'h0200, 32'h0004_0000);
        pop();

`ifdef SQUARE_ROUND_EN
        launch("round 0x0B50", 16'h0B50, 32'h007F_F900);
        check("round 0x0B50 out_int", 32'(out_int), 32'h80);
        pop();
`endif

        // Back-to-back stream with out_ready tied high.
        begin
            int  idx  = 0;
            int  nres = 0;
            logic acc_now, res_now;
            for (int i = 0; i < 3; i++) res[i] = '0;
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 200 && nres < 3; cyc++) begin
                in_valid = (idx < 3);
                in_data  = ops[(idx < 3) ? idx : 2];
                acc_now  = in_ready && in_valid;
                res_now  = out_valid;
                if (res_now) res[nres] = out_data;
                tick();
                if (acc_now) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                end
                if (res_now) nres++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("stream results seen", 32'(nres), 32'd3);
            for (int i = 0; i < 3; i++) check("stream result", res[i], sqs[i]);
            check("stream spacing 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd18);
            check("stream spacing 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd18);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
